// File: rtl/keypad_pkg.sv
// Shared types for keypad_scan_fifo: keycodes, index-to-code table,
// scan FSM states and the "no single key" sample value.
package keypad_pkg;

  typedef logic [3:0] keycode_t;
  typedef logic [4:0] sample_t;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_e;

  localparam keycode_t KEY_0 = 4'h0;
  localparam keycode_t KEY_1 = 4'h1;
  localparam keycode_t KEY_2 = 4'h2;
  localparam keycode_t KEY_3 = 4'h3;
  localparam keycode_t KEY_4 = 4'h4;
  localparam keycode_t KEY_5 = 4'h5;
  localparam keycode_t KEY_6 = 4'h6;
  localparam keycode_t KEY_7 = 4'h7;
  localparam keycode_t KEY_8 = 4'h8;
  localparam keycode_t KEY_9 = 4'h9;
  localparam keycode_t KEY_A = 4'hA;
  localparam keycode_t KEY_B = 4'hB;
  localparam keycode_t KEY_C = 4'hC;
  localparam keycode_t KEY_D = 4'hD;
  localparam keycode_t KEY_E = 4'hE;
  localparam keycode_t KEY_F = 4'hF;

  // Row-major physical layout of the standard 4x4 pad
  localparam keycode_t KEY_TABLE [16] = '{
    KEY_1, KEY_2, KEY_3, KEY_A,
    KEY_4, KEY_5, KEY_6, KEY_B,
    KEY_7, KEY_8, KEY_9, KEY_C,
    KEY_E, KEY_0, KEY_F, KEY_D
  };

  localparam sample_t SAMPLE_NONE = 5'h10;

  function automatic keycode_t key_of(
    input logic [3:0] idx
  );
    return KEY_TABLE[idx];
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Keycode FIFO with registered head, valid and count.
// Push into a full FIFO is only accepted when a pop happens the same cycle.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  keycode_t      wdata,
  input  logic          pop,
  output keycode_t      head,
  output logic          valid,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  keycode_t      mem_q [DEPTH];
  keycode_t      mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  keycode_t      head_q, head_d;
  logic          valid_q, valid_d;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    mem_d   = mem_q;
    if (push_ok) begin
      mem_d[wr_q] = wdata;
    end
    wr_d    = wr_q + AW'(push_ok);
    rd_d    = rd_q + AW'(pop_ok);
    cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
    valid_d = (cnt_d != '0);
    // New head bypasses memory when it lands in a drained FIFO
    if (!valid_d) begin
      head_d = '0;
    end else if (push_ok && (rd_d == wr_q)) begin
      head_d = wdata;
    end else begin
      head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  assign head  = head_q;
  assign valid = valid_q;
  assign count = cnt_q;

endmodule

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner, debouncer and event FIFO.
// Define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int NROWS     = 4,
  parameter int NCOLS     = 4,
  parameter int SCAN_DIV  = 500,
  parameter int DEB_TICKS = 20,
  parameter int DEPTH     = 8,
  parameter int REP_DELAY = 400,
  parameter int REP_RATE  = 100
) (
  input  logic                     CLOCK_50,
  input  logic                     Reset,
  output logic [NCOLS-1:0]         col_n,
  input  logic [NROWS-1:0]         row_n,
  output logic [3:0]               key_code,
  output logic                     key_valid,
  input  logic                     key_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     key_held,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int CLW = $clog2(NCOLS);
  localparam int DVW = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEB_TICKS);
  localparam int CW  = $clog2(DEPTH) + 1;

  logic [DVW-1:0]   div_q, div_d;
  logic             tick_q, tick_d;
  logic [NROWS-1:0] row_s_q;
  state_e           state_q, state_d;
  logic [CLW-1:0]   col_q, col_d;
  logic [NCOLS-1:0] coln_q, coln_d;
  sample_t          last_q, last_d;
  logic [DBW-1:0]   cnt_q, cnt_d;
  logic             held_q, held_d;
  logic             push_q, push_d;
  keycode_t         pcode_q, pcode_d;
  logic             ovf_q, ovf_d;

  logic [NROWS-1:0] low;
  logic [1:0]       row_idx;
  logic             any_low;
  logic             one_low;
  sample_t          sample;

  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             drop;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RPW  = $clog2(RMAX + 1);
  logic [RPW-1:0] rep_q, rep_d;
`endif

  always_comb begin
    tick_d = (div_q == DVW'(SCAN_DIV - 1));
    div_d  = tick_d ? '0 : div_q + DVW'(1);
  end

  always_comb begin
    low     = ~row_s_q;
    any_low = |low;
    one_low = any_low && ((low & (low - 1'b1)) == '0);
    row_idx = '0;
    for (int r = 0; r < NROWS; r++) begin
      if (low[r]) begin
        row_idx = 2'(r);
      end
    end
    sample = one_low
           ? sample_t'(row_idx) * sample_t'(NCOLS) + sample_t'(col_q)
           : SAMPLE_NONE;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    push_d  = 1'b0;
    pcode_d = pcode_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    if (tick_q) begin
      unique case (state_q)
        SCAN: begin
          if (any_low) begin
            state_d = DEBOUNCE;
            last_d  = sample;
            cnt_d   = DBW'(1);
          end else if (col_q == CLW'(NCOLS - 1)) begin
            col_d = '0;
          end else begin
            col_d = col_q + CLW'(1);
          end
        end
        DEBOUNCE: begin
          if (sample != last_q) begin
            last_d = sample;
            cnt_d  = DBW'(1);
          end else if (cnt_q == DBW'(DEB_TICKS - 1)) begin
            cnt_d = '0;
            if (sample == SAMPLE_NONE) begin
              state_d = SCAN;
            end else begin
              state_d = PRESSED;
              held_d  = 1'b1;
              push_d  = 1'b1;
              pcode_d = key_of(sample[3:0]);
`ifdef KEYPAD_REPEAT_EN
              rep_d   = RPW'(REP_DELAY);
`endif
            end
          end else begin
            cnt_d = cnt_q + DBW'(1);
          end
        end
        PRESSED: begin
          // Any key activity restarts the release count
          if (sample != SAMPLE_NONE) begin
            cnt_d = '0;
          end else if (cnt_q == DBW'(DEB_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = SCAN;
            held_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + DBW'(1);
          end
`ifdef KEYPAD_REPEAT_EN
          if (rep_q == RPW'(1)) begin
            push_d = 1'b1;
            rep_d  = RPW'(REP_RATE);
          end else begin
            rep_d = rep_q - RPW'(1);
          end
`endif
        end
        default: begin
          state_d = SCAN;
        end
      endcase
    end
    coln_d = ~(NCOLS'(1) << col_d);
  end

  always_comb begin
    pop   = key_ready & ~fifo_empty;
    drop  = push_q & fifo_full & ~pop;
    ovf_d = (ovf_q & ~ovf_clr) | drop;
  end

  // One sync stage only: rows must settle within one tick of a column change
  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      row_s_q <= '1;
      state_q <= SCAN;
      col_q   <= '0;
      coln_q  <= ~(NCOLS'(1));
      last_q  <= SAMPLE_NONE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      push_q  <= 1'b0;
      pcode_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      row_s_q <= row_n;
      state_q <= state_d;
      col_q   <= col_d;
      coln_q  <= coln_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      push_q  <= push_d;
      pcode_q <= pcode_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  key_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (Reset),
    .push  (push_q),
    .wdata (pcode_q),
    .pop   (pop),
    .head  (key_code),
    .valid (key_valid),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign col_n    = coln_q;
  assign key_held = held_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: emulated key matrix plus a queue model
// of pressed keycodes; directed steps and random press batches.
module tb_keypad_scan_fifo;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int SD = 4;
  localparam int DT = 3;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] col_n;
  logic [NR-1:0] row_n;
  logic [3:0]    key_code;
  logic          key_valid;
  logic          key_ready;
  logic [2:0]    fifo_count;
  logic          key_held;
  logic          overflow;
  logic          ovf_clr;

  logic [15:0]   keys;
  logic [3:0]    exp_q [$];
  logic          exp_ovf;
  int            checks = 0;
  int            errors = 0;

  logic [3:0] tbl [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  always #5 clk = ~clk;

  always_comb begin
    row_n = '1;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        if (keys[r*NC+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  keypad_scan_fifo #(
    .NROWS     (NR),
    .NCOLS     (NC),
    .SCAN_DIV  (SD),
    .DEB_TICKS (DT),
    .DEPTH     (DP),
    .REP_DELAY (5),
    .REP_RATE  (2)
  ) dut (
    .CLOCK_50   (clk),
    .Reset      (rst_n),
    .col_n      (col_n),
    .row_n      (row_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .fifo_count (fifo_count),
    .key_held   (key_held),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n * SD) @(negedge clk);
  endtask

  task automatic wait_held(input logic v, input string tag);
    int n = 0;
    while (key_held !== v && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, key_held, v);
  endtask

  function automatic void model_push(input logic [3:0] code);
    if (exp_q.size() < DP) exp_q.push_back(code);
    else exp_ovf = 1'b1;
  endfunction

  task automatic press(input int idx);
    keys = 16'(1) << idx;
    wait_held(1'b1, "press_on");
    keys = '0;
    wait_held(1'b0, "press_off");
    ticks(1);
    model_push(tbl[idx]);
  endtask

  task automatic pop1();
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() != 0) begin
      chk({tag, "_valid"}, key_valid, 1);
      chk({tag, "_code"}, key_code, exp_q[0]);
      void'(exp_q.pop_front());
      pop1();
    end
    chk({tag, "_empty"}, fifo_count, 0);
    chk({tag, "_nvalid"}, key_valid, 0);
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    chk("ovf_clr", overflow, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_col"}, col_n, 4'b1110);
    chk({tag, "_code"}, key_code, 0);
    chk({tag, "_valid"}, key_valid, 0);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_held"}, key_held, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    int idx;
    int n;
    keys      = '0;
    key_ready = 1'b0;
    ovf_clr   = 1'b0;
    exp_ovf   = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    ticks(2);

    // Row 0 / column 1 held: one entry, code 2
    keys = 16'(1) << 1;
    wait_held(1'b1, "t1_held");
`ifndef KEYPAD_REPEAT_EN
    ticks(9);
`else
    ticks(1);
`endif
    chk("t1_count", fifo_count, 1);
    chk("t1_valid", key_valid, 1);
    chk("t1_code", key_code, 4'h2);
    chk("t1_keyheld", key_held, 1);
    keys = '0;
    wait_held(1'b0, "t1_rel");
    ticks(1);
    model_push(tbl[1]);
    drain("t1");

    // Bouncing contact then stable
    for (int i = 0; i < 4; i++) begin
      keys = (i % 2 == 0) ? (16'(1) << 6) : '0;
      ticks(1);
    end
    keys = 16'(1) << 6;
    wait_held(1'b1, "bnc_held");
    keys = '0;
    wait_held(1'b0, "bnc_rel");
    ticks(2);
    model_push(tbl[6]);
    chk("bnc_count", fifo_count, 1);
    drain("bnc");

    // Five presses with no consumer
    for (int i = 0; i < 5; i++) press(int'($urandom_range(0, 15)));
    chk("ovf_count", fifo_count, DP);
    chk("ovf_flag", overflow, exp_ovf);
    drain("ovf");
    clear_ovf();

    // Full FIFO, push and pop in the same cycle
    for (int i = 0; i < 4; i++) press(int'($urandom_range(0, 15)));
    idx  = int'($urandom_range(0, 15));
    keys = 16'(1) << idx;
    wait_held(1'b1, "fp_held");
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(tbl[idx]);
    keys = '0;
    wait_held(1'b0, "fp_rel");
    chk("fp_count", fifo_count, DP);
    chk("fp_ovf", overflow, 0);
    drain("fp");

    // Two rows low on one column
    keys = (16'(1) << 1) | (16'(1) << 9);
    ticks(10);
    chk("multi_held", key_held, 0);
    chk("multi_count", fifo_count, 0);
    keys = '0;
    ticks(3);

    // Random batches against the queue model
    for (int b = 0; b < 3; b++) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) press(int'($urandom_range(0, 15)));
      chk("rnd_count", fifo_count, exp_q.size());
      chk("rnd_ovf", overflow, exp_ovf);
      drain("rnd");
      clear_ovf();
    end

`ifdef KEYPAD_REPEAT_EN
    begin
      int pops = 0;
      int hold_c = 0;
      int post = 0;
      logic released = 1'b0;
      idx = 5;
      key_ready = 1'b1;
      keys = 16'(1) << idx;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        if (key_valid) begin
          chk("rep_code", key_code, tbl[idx]);
          pops++;
        end
        if (!released && key_held) begin
          hold_c++;
          if (hold_c == 36) begin
            keys = '0;
            released = 1'b1;
          end
        end
        if (released && !key_held) post++;
        if (post == 40) break;
      end
      key_ready = 1'b0;
      chk("rep_pushes", pops, 5);
      chk("rep_ovf", overflow, 0);
    end
`endif

    // Reset in the middle of a press
    keys = 16'(1) << 10;
    wait_held(1'b1, "mid_held");
    rst_n = 1'b0;
    #2;
    check_reset("mid_rst");
    keys = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ticks(2);
    chk("post_rst_count", fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
